// File: rtl/vth_read_sense.sv
// Two-step binary-search read sense: decides a 2-bit MLC level from a captured Vth.
// Optional read-retry reference shift is enabled by defining READ_RETRY_EN.
module vth_read_sense #(
  parameter int unsigned SENSE_CYCLES = 4,
  parameter logic [15:0] REF0         = 16'h4000,
  parameter logic [15:0] REF1         = 16'h8000,
  parameter logic [15:0] REF2         = 16'hC000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [15:0] Vth,
`ifdef READ_RETRY_EN
  input  logic [7:0]  RetryOffset,
`endif
  output logic        Busy,
  output logic        Valid,
  output logic [1:0]  ReadLevel,
  output logic [15:0] ReadCount
);

  // state      | meaning
  // IDLE       | waiting for Start; Vth (and offset) captured on accept
  // SENSE_MID  | compare against R1, result becomes msb
  // SENSE_SIDE | compare against R2 or R0 depending on msb
  // DONE       | one-cycle Valid with the new level and count

  localparam int unsigned STEP_W = (SENSE_CYCLES > 1) ? $clog2(SENSE_CYCLES) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(SENSE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SENSE_MID  = 2'd1,
    SENSE_SIDE = 2'd2,
    DONE       = 2'd3
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [STEP_W-1:0] step;
  logic [STEP_W-1:0] step_next;
  logic [15:0]       vth_lat;
  logic              msb;
  logic              lsb;
  logic              capture;
  logic              take_msb;
  logic              finish;
  logic [15:0]       r0;
  logic [15:0]       r1;
  logic [15:0]       r2;
  logic [1:0]        level_q;
  logic [15:0]       read_cnt;

`ifdef READ_RETRY_EN
  logic [7:0] off_lat;

  // Shifted references saturate rather than wrap so a large offset can never
  // reorder the three thresholds.
  function automatic logic [15:0] eff_ref(input logic [15:0] base, input logic [7:0] off);
    logic signed [17:0] sum;
    sum = $signed({2'b00, base}) + $signed({{10{off[7]}}, off});
    if (sum < 0)
      eff_ref = '0;
    else if (sum > 18'sh0FFFF)
      eff_ref = '1;
    else
      eff_ref = sum[15:0];
  endfunction

  always_ff @(posedge clk) begin
    if (reset)
      off_lat <= '0;
    else if (capture)
      off_lat <= RetryOffset;
  end

  assign r0 = eff_ref(REF0, off_lat);
  assign r1 = eff_ref(REF1, off_lat);
  assign r2 = eff_ref(REF2, off_lat);
`else
  assign r0 = REF0;
  assign r1 = REF1;
  assign r2 = REF2;
`endif

  assign lsb = msb ? (vth_lat >= r2) : (vth_lat >= r0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      step     <= '0;
      vth_lat  <= '0;
      msb      <= 1'b0;
      level_q  <= '0;
      read_cnt <= '0;
    end else begin
      state <= state_next;
      step  <= step_next;
      if (capture)
        vth_lat <= Vth;
      if (take_msb)
        msb <= (vth_lat >= r1);
      // Level and count update on entry to DONE so both are visible with Valid.
      if (finish) begin
        level_q  <= {msb, lsb};
        read_cnt <= read_cnt + 16'd1;
      end
    end
  end

  always_comb begin
    state_next = state;
    step_next  = step;
    capture    = 1'b0;
    take_msb   = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        step_next = '0;
        if (Start) begin
          capture    = 1'b1;
          state_next = SENSE_MID;
        end
      end
      SENSE_MID: begin
        if (step == STEP_LAST) begin
          take_msb   = 1'b1;
          step_next  = '0;
          state_next = SENSE_SIDE;
        end else begin
          step_next = step + STEP_W'(1);
        end
      end
      SENSE_SIDE: begin
        if (step == STEP_LAST) begin
          finish     = 1'b1;
          step_next  = '0;
          state_next = DONE;
        end else begin
          step_next = step + STEP_W'(1);
        end
      end
      DONE: begin
        step_next  = '0;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign Busy      = (state != IDLE);
  assign Valid     = (state == DONE);
  assign ReadLevel = level_q;
  assign ReadCount = read_cnt;

endmodule

// File: tb/tb_vth_read_sense.sv
// Randomized self-checking bench for vth_read_sense against a threshold-count model.
// Define READ_RETRY_EN to also exercise the read-retry offset path.
`timescale 1ns/1ps
module tb_vth_read_sense;

  localparam int SC     = 4;
  localparam int LAT    = 2 * SC;      // posedges after the accepting edge until Valid is seen
  localparam int PERIOD = 2 + 2 * SC;  // cycles per read when Start is held
  localparam int REF0   = 16'h4000;
  localparam int REF1   = 16'h8000;
  localparam int REF2   = 16'hC000;
`ifdef READ_RETRY_EN
  localparam bit RETRY_ON = 1'b1;
`else
  localparam bit RETRY_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [15:0] Vth;
  logic [7:0]  RetryOffset;
  logic        Busy;
  logic        Valid;
  logic [1:0]  ReadLevel;
  logic [15:0] ReadCount;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [15:0] exp_count   = 16'd0;

  always #5 clk = ~clk;

  vth_read_sense #(.SENSE_CYCLES(SC)) dut (
    .clk(clk), .reset(reset), .Start(Start), .Vth(Vth),
`ifdef READ_RETRY_EN
    .RetryOffset(RetryOffset),
`endif
    .Busy(Busy), .Valid(Valid), .ReadLevel(ReadLevel), .ReadCount(ReadCount)
  );

`ifdef READ_RETRY_EN
  logic        Busy2;
  logic        Valid2;
  logic [1:0]  ReadLevel2;
  logic [15:0] ReadCount2;
  logic [1:0]  lvl2_seen;
  logic        valid2_seen;

  vth_read_sense #(.SENSE_CYCLES(SC), .REF2(16'hFFF0)) dut2 (
    .clk(clk), .reset(reset), .Start(Start), .Vth(Vth), .RetryOffset(RetryOffset),
    .Busy(Busy2), .Valid(Valid2), .ReadLevel(ReadLevel2), .ReadCount(ReadCount2)
  );
`endif

  // Level = number of (saturated, shifted) references at or below Vth.
  function automatic int model_level(int vth, int off, int ref2);
    int base[3];
    int lvl;
    int r;
    base = '{REF0, REF1, ref2};
    lvl  = 0;
    for (int i = 0; i < 3; i++) begin
      r = base[i] + off;
      if (r < 0) r = 0;
      if (r > 65535) r = 65535;
      if (vth >= r) lvl++;
    end
    return lvl;
  endfunction

  function automatic int eff_off(logic [7:0] o);
    return RETRY_ON ? int'($signed(o)) : 0;
  endfunction

  // One read from IDLE; optionally disturbs Vth and pulses Start while busy.
  task automatic run_read(input logic [15:0] v, input logic [7:0] off, input bit disturb,
                          output logic [1:0] lvl, output logic [15:0] cnt, output int lat,
                          output logic busy_first, output logic busy_done, output logic busy_after);
    lat = -1; lvl = 'x; cnt = 'x; busy_first = 'x; busy_done = 'x; busy_after = 'x;
    @(negedge clk);
    Vth = v; RetryOffset = off; Start = 1'b1;
    @(posedge clk);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (n == 0) begin Start = 1'b0; busy_first = Busy; end
      if (disturb) begin
        if (n == 2) begin Vth = 16'hF000; Start = 1'b1; end
        if (n == 3) Start = 1'b0;
        if (n == 5) Start = 1'b1;
        if (n == 6) Start = 1'b0;
      end
      if (Valid) begin
        lat = n; lvl = ReadLevel; cnt = ReadCount; busy_done = Busy;
`ifdef READ_RETRY_EN
        lvl2_seen = ReadLevel2; valid2_seen = Valid2;
`endif
        break;
      end
    end
    @(negedge clk);
    busy_after = Busy;
  endtask

  task automatic test_reset();
    reset = 1'b1; Start = 1'b0; Vth = '0; RetryOffset = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++; if (Busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", Busy); end
    vectors++; if (Valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", Valid); end
    vectors++; if (ReadLevel !== 2'd0) begin miscompares++; $display("FAIL reset_level: got %0d want 0", ReadLevel); end
    vectors++; if (ReadCount !== 16'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", ReadCount); end
    reset = 1'b0;
  endtask

  task automatic test_reset_mid_read();
    int nvalid;
    nvalid = 0;
    @(negedge clk);
    Start = 1'b1; Vth = 16'h9000;
    @(posedge clk);
    @(negedge clk); Start = 1'b0;
    vectors++; if (Busy !== 1'b1) begin miscompares++; $display("FAIL midreset_busy_before: got %b want 1", Busy); end
    @(negedge clk);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    vectors++; if (Busy !== 1'b0) begin miscompares++; $display("FAIL midreset_busy: got %b want 0", Busy); end
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (Valid) nvalid++;
    end
    vectors++; if (nvalid != 0) begin miscompares++; $display("FAIL midreset_valid: got %0d pulses want 0", nvalid); end
    vectors++; if (ReadCount !== 16'd0) begin miscompares++; $display("FAIL midreset_count: got %0d want 0", ReadCount); end
    vectors++; if (ReadLevel !== 2'd0) begin miscompares++; $display("FAIL midreset_level: got %0d want 0", ReadLevel); end
  endtask

  task automatic test_levels();
    logic [15:0] vin[7];
    int          want[7];
    logic [1:0]  lvl;
    logic [15:0] cnt;
    int          lat;
    logic        bf, bd, ba;
    vin  = '{16'h1234, 16'h4000, 16'h8001, 16'hFFFF, 16'h3FFF, 16'hBFFF, 16'hC000};
    want = '{0, 1, 2, 3, 0, 2, 3};
    for (int i = 0; i < 7; i++) begin
      run_read(vin[i], 8'h00, 1'b0, lvl, cnt, lat, bf, bd, ba);
      exp_count++;
      vectors++; if (lat != LAT) begin miscompares++; $display("FAIL level_latency[%0d]: got %0d want %0d", i, lat, LAT); end
      vectors++; if (lvl !== 2'(want[i])) begin miscompares++; $display("FAIL level[%h]: got %0d want %0d", vin[i], lvl, want[i]); end
      vectors++; if (cnt !== exp_count) begin miscompares++; $display("FAIL level_count[%0d]: got %0d want %0d", i, cnt, exp_count); end
      vectors++; if ({bf, bd, ba} !== 3'b110) begin miscompares++; $display("FAIL level_busy[%0d]: got %b want 110", i, {bf, bd, ba}); end
      if (i == 3) begin
        vectors++; if (ReadCount !== 16'd4) begin miscompares++; $display("FAIL level_count_four: got %0d want 4", ReadCount); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int vt[$];
    int lv[$];
    int cn[$];
    vt.delete(); lv.delete(); cn.delete();
    Vth = 16'h7000; RetryOffset = 8'h00;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (Valid) begin vt.push_back(i); lv.push_back(int'(ReadLevel)); cn.push_back(int'(ReadCount)); end
      Start = (i < 30);
    end
    Start = 1'b0;
    vectors++; if (vt.size() != (30 + PERIOD - 1) / PERIOD) begin miscompares++; $display("FAIL b2b_reads: got %0d want %0d", vt.size(), (30 + PERIOD - 1) / PERIOD); end
    for (int k = 0; k < vt.size(); k++) begin
      exp_count++;
      vectors++; if (vt[k] != 1 + LAT + k * PERIOD) begin miscompares++; $display("FAIL b2b_time[%0d]: got %0d want %0d", k, vt[k], 1 + LAT + k * PERIOD); end
      vectors++; if (lv[k] != model_level(16'h7000, 0, REF2)) begin miscompares++; $display("FAIL b2b_level[%0d]: got %0d want %0d", k, lv[k], model_level(16'h7000, 0, REF2)); end
      vectors++; if (cn[k] != int'(exp_count)) begin miscompares++; $display("FAIL b2b_count[%0d]: got %0d want %0d", k, cn[k], exp_count); end
    end
  endtask

  task automatic test_ignore_start();
    logic [1:0]  lvl;
    logic [15:0] cnt;
    int          lat;
    int          extra;
    logic        bf, bd, ba;
    extra = 0;
    run_read(16'h2000, 8'h00, 1'b1, lvl, cnt, lat, bf, bd, ba);
    exp_count++;
    vectors++; if (lat != LAT) begin miscompares++; $display("FAIL ignore_latency: got %0d want %0d", lat, LAT); end
    vectors++; if (lvl !== 2'd0) begin miscompares++; $display("FAIL ignore_level: got %0d want 0", lvl); end
    for (int i = 0; i < 2 * PERIOD; i++) begin
      @(negedge clk);
      if (Valid) extra++;
    end
    vectors++; if (extra != 0) begin miscompares++; $display("FAIL ignore_extra_reads: got %0d want 0", extra); end
    vectors++; if (ReadCount !== exp_count) begin miscompares++; $display("FAIL ignore_count: got %0d want %0d", ReadCount, exp_count); end
  endtask

  task automatic test_random();
    int          refs[3];
    logic [15:0] v;
    logic [7:0]  o;
    logic [1:0]  lvl;
    logic [15:0] cnt;
    int          lat;
    int          want;
    logic        bf, bd, ba;
    refs = '{REF0, REF1, REF2};
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 1) == 0)
        v = 16'($urandom);
      else
        v = 16'(refs[$urandom_range(0, 2)] + int'($urandom_range(0, 6)) - 3);
      o = 8'($urandom);
      run_read(v, o, 1'b0, lvl, cnt, lat, bf, bd, ba);
      exp_count++;
      want = model_level(int'(v), eff_off(o), REF2);
      vectors++; if (lat != LAT) begin miscompares++; $display("FAIL rand_latency[%0d]: got %0d want %0d", i, lat, LAT); end
      vectors++; if (lvl !== 2'(want)) begin miscompares++; $display("FAIL rand_level[vth=%h off=%h]: got %0d want %0d", v, o, lvl, want); end
      vectors++; if (cnt !== exp_count) begin miscompares++; $display("FAIL rand_count[%0d]: got %0d want %0d", i, cnt, exp_count); end
    end
  endtask

`ifdef READ_RETRY_EN
  task automatic test_retry();
    logic [7:0]  offs[4];
    logic [15:0] vin[4];
    int          want[4];
    bit          second[4];
    logic [1:0]  lvl;
    logic [15:0] cnt;
    int          lat;
    logic        bf, bd, ba;
    offs   = '{8'h80, 8'h7F, 8'h7F, 8'h7F};
    vin    = '{16'h3F90, 16'h4070, 16'hFFFF, 16'hFFFE};
    want   = '{1, 0, 3, 2};
    second = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      run_read(vin[i], offs[i], 1'b0, lvl, cnt, lat, bf, bd, ba);
      exp_count++;
      if (second[i]) begin
        vectors++; if (valid2_seen !== 1'b1) begin miscompares++; $display("FAIL retry_valid2[%0d]: got %b want 1", i, valid2_seen); end
        vectors++; if (lvl2_seen !== 2'(want[i])) begin miscompares++; $display("FAIL retry_sat_level[%h]: got %0d want %0d", vin[i], lvl2_seen, want[i]); end
      end else begin
        vectors++; if (lvl !== 2'(want[i])) begin miscompares++; $display("FAIL retry_level[%h]: got %0d want %0d", vin[i], lvl, want[i]); end
      end
    end
  endtask
`endif

  task automatic test_wrap();
    logic [1:0]  lvl;
    logic [15:0] cnt;
    int          lat;
    logic        bf, bd, ba;
    @(negedge clk);
    force dut.read_cnt = 16'hFFFF;
    #1 release dut.read_cnt;
    exp_count = 16'hFFFF;
    #1;
    vectors++; if (ReadCount !== exp_count) begin miscompares++; $display("FAIL wrap_preload: got %h want %h", ReadCount, exp_count); end
    run_read(16'h9000, 8'h00, 1'b0, lvl, cnt, lat, bf, bd, ba);
    exp_count++;
    vectors++; if (cnt !== exp_count) begin miscompares++; $display("FAIL wrap_count: got %h want %h", cnt, exp_count); end
    vectors++; if (lvl !== 2'd2) begin miscompares++; $display("FAIL wrap_level: got %0d want 2", lvl); end
  endtask

  initial begin
    test_reset();
    test_reset_mid_read();
    test_levels();
    test_back_to_back();
    test_ignore_start();
    test_random();
`ifdef READ_RETRY_EN
    test_retry();
`endif
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
